// File: rtl/melody_if.sv
// Melody-load interface between the melody writer (master) and the game module side (slave).
// Carries gen_random only when RANDOM_MELODY_EN is defined.
interface melody_if;
   logic        record_start;
   logic [2:0]  note_in;
   logic        note_valid;
   logic        note_ready;
   logic        commit;
   logic        game_end;
   logic [31:0] data_out;
   logic        write_enable;
   logic        game_start;
   logic [3:0]  note_count;
   logic        busy;
   logic        err;
`ifdef RANDOM_MELODY_EN
   logic        gen_random;
`endif

   modport master (
`ifdef RANDOM_MELODY_EN
      input  gen_random,
`endif
      input  record_start, note_in, note_valid, commit, game_end,
      output note_ready, data_out, write_enable, game_start, note_count, busy, err
   );

   modport slave (
`ifdef RANDOM_MELODY_EN
      output gen_random,
`endif
      output record_start, note_in, note_valid, commit, game_end,
      input  note_ready, data_out, write_enable, game_start, note_count, busy, err
   );
endinterface

// File: rtl/melody_writer.sv
// Melody writer: records keypad notes into a packed 32-bit word, then strobes load and start.
// Optional LFSR melody fill is enabled with the RANDOM_MELODY_EN macro.
//
// state  | meaning
// IDLE   | waiting for record_start (or gen_random)
// RECORD | accepting keypad notes, note_ready=1
// FILL   | LFSR fills all slots, one per cycle (RANDOM_MELODY_EN only)
// WRITE  | write_enable pulse, data_out final
// GAP    | START_DELAY quiet cycles
// START  | game_start pulse
// ARMED  | holding data_out until game_end
module melody_writer #(
   parameter int          NUM_NOTES   = 8,
   parameter int          MIN_NOTES   = 2,
   parameter int          START_DELAY = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   melody_if.master   io_mel
);

   localparam int GW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

`ifdef RANDOM_MELODY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_RECORD, S_WRITE, S_GAP, S_START, S_ARMED, S_FILL
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RECORD, S_WRITE, S_GAP, S_START, S_ARMED
   } state_t;
`endif

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_data;
   logic [3:0]    r_count;
   logic [GW-1:0] r_gap;
   logic          r_err;

   logic          w_clear;
   logic          w_store;
   logic [2:0]    w_note;
   logic          w_err_nxt;
   logic [3:0]    w_cnt_after;

`ifdef RANDOM_MELODY_EN
   logic [15:0]   r_lfsr;
   logic          w_lfsr_fb;
   logic [2:0]    w_rand_note;

   // Fibonacci taps 16,14,13,11; note 0 is mapped to 1 so random notes are never rests
   assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_rand_note = (r_lfsr[2:0] == 3'd0) ? 3'd1 : r_lfsr[2:0];

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_lfsr <= LFSR_SEED;
      else          r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_store     = 1'b0;
      w_note      = 3'd0;
      w_err_nxt   = 1'b0;
      w_cnt_after = r_count;
      case (r_state)
         S_IDLE: begin
            if (io_mel.record_start) begin
               w_clear     = 1'b1;
               w_state_nxt = S_RECORD;
            end
`ifdef RANDOM_MELODY_EN
            else if (io_mel.gen_random) begin
               w_clear     = 1'b1;
               w_state_nxt = S_FILL;
            end
`endif
         end
         S_RECORD: begin
            if (io_mel.record_start) begin
               w_clear = 1'b1;
            end else begin
               if (io_mel.note_valid) begin
                  if (io_mel.note_in != 3'd0) begin
                     w_store = 1'b1;
                     w_note  = io_mel.note_in;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
               // commit is judged against the count including a same-cycle note
               w_cnt_after = r_count + {3'd0, w_store};
               if (w_store && (w_cnt_after == 4'(NUM_NOTES))) begin
                  w_state_nxt = S_WRITE;
               end else if (io_mel.commit) begin
                  if (w_cnt_after >= 4'(MIN_NOTES)) w_state_nxt = S_WRITE;
                  else                              w_err_nxt   = 1'b1;
               end
            end
         end
`ifdef RANDOM_MELODY_EN
         S_FILL: begin
            w_store     = 1'b1;
            w_note      = w_rand_note;
            w_cnt_after = r_count + 4'd1;
            if (w_cnt_after == 4'(NUM_NOTES)) w_state_nxt = S_WRITE;
         end
`endif
         S_WRITE: w_state_nxt = S_GAP;
         S_GAP: begin
            if (r_gap == '0) w_state_nxt = S_START;
         end
         S_START: w_state_nxt = S_ARMED;
         S_ARMED: begin
            if (io_mel.game_end) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_data  <= 32'd0;
         r_count <= 4'd0;
         r_gap   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
         if (w_clear) begin
            r_data  <= 32'd0;
            r_count <= 4'd0;
         end else if (w_store && (r_count < 4'(NUM_NOTES))) begin
            for (int k = 0; k < NUM_NOTES; k++) begin
               if (r_count == 4'(k)) r_data[4*k +: 4] <= {1'b0, w_note};
            end
            r_count <= r_count + 4'd1;
         end
         // gap timer: loaded while in WRITE, counts down to terminal zero in GAP
         if (r_state == S_WRITE)                  r_gap <= GW'(START_DELAY - 1);
         else if (r_state == S_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
      end
   end

   assign io_mel.data_out     = r_data;
   assign io_mel.note_count   = r_count;
   assign io_mel.note_ready   = (r_state == S_RECORD);
   assign io_mel.write_enable = (r_state == S_WRITE);
   assign io_mel.game_start   = (r_state == S_START);
   assign io_mel.busy         = (r_state != S_IDLE);
   assign io_mel.err          = r_err;

endmodule

// File: tb/tb_melody_writer.sv
// Directed bench for melody_writer with default parameters (NUM_NOTES=8, MIN_NOTES=2, START_DELAY=2).
module tb_melody_writer;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   melody_if mif ();

   melody_writer #(
      .NUM_NOTES  (8),
      .MIN_NOTES  (2),
      .START_DELAY(2),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .io_mel (mif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic note(input logic [2:0] n);
      mif.note_valid = 1'b1;
      mif.note_in    = n;
      tick();
      mif.note_valid = 1'b0;
      mif.note_in    = 3'd0;
   endtask

   task automatic pulse_start();
      mif.record_start = 1'b1;
      tick();
      mif.record_start = 1'b0;
   endtask

   initial begin
      reset            = 1'b0;
      mif.record_start = 1'b0;
      mif.note_in      = 3'd0;
      mif.note_valid   = 1'b0;
      mif.commit       = 1'b0;
      mif.game_end     = 1'b0;
      @(negedge clk);

      // 1: reset
      tick(); tick();
      check("rst_data", mif.data_out, 32'd0);
      check("rst_cnt", {28'd0, mif.note_count}, 32'd0);
      check("rst_outs", {26'd0, mif.note_ready, mif.write_enable, mif.game_start,
                         mif.busy, mif.err, 1'b0}, 32'd0);
      reset = 1'b1;

      // commit and notes ignored in IDLE
      mif.commit = 1'b1; mif.note_valid = 1'b1; mif.note_in = 3'd5;
      tick();
      mif.commit = 1'b0; mif.note_valid = 1'b0; mif.note_in = 3'd0;
      check("idle_ign_busy", {31'd0, mif.busy}, 32'd0);
      check("idle_ign_cnt", {28'd0, mif.note_count}, 32'd0);

      // 2: 3,5,1 then commit
      pulse_start();
      check("rec_ready", {31'd0, mif.note_ready}, 32'd1);
      check("rec_busy", {31'd0, mif.busy}, 32'd1);
      note(3'd3); note(3'd5); note(3'd1);
      check("t2_cnt", {28'd0, mif.note_count}, 32'd3);
      check("t2_we_early", {31'd0, mif.write_enable}, 32'd0);
      mif.commit = 1'b1;
      tick();
      mif.commit = 1'b0;
      check("t2_we", {31'd0, mif.write_enable}, 32'd1);
      check("t2_data", mif.data_out, 32'h0000_0153);
      check("t2_ready_off", {31'd0, mif.note_ready}, 32'd0);
      tick();
      check("t2_gap1", {30'd0, mif.write_enable, mif.game_start}, 32'd0);
      tick();
      check("t2_gap2", {30'd0, mif.write_enable, mif.game_start}, 32'd0);
      tick();
      check("t2_gs", {31'd0, mif.game_start}, 32'd1);
      tick();
      check("t2_gs_off", {31'd0, mif.game_start}, 32'd0);
      check("t2_armed_busy", {31'd0, mif.busy}, 32'd1);
      // ARMED ignores record_start
      pulse_start();
      check("armed_ign_data", mif.data_out, 32'h0000_0153);
      check("armed_ign_ready", {31'd0, mif.note_ready}, 32'd0);
      mif.game_end = 1'b1;
      tick();
      mif.game_end = 1'b0;
      check("t6_idle_busy", {31'd0, mif.busy}, 32'd0);
      check("t2_hold_data", mif.data_out, 32'h0000_0153);

      // 3: rejected commit and rest note
      pulse_start();
      check("t3_clr_data", mif.data_out, 32'd0);
      note(3'd4);
      mif.commit = 1'b1;
      tick();
      mif.commit = 1'b0;
      check("t3_err_commit", {31'd0, mif.err}, 32'd1);
      check("t3_still_rec", {31'd0, mif.note_ready}, 32'd1);
      check("t3_cnt1", {28'd0, mif.note_count}, 32'd1);
      note(3'd0);
      check("t3_err_rest", {31'd0, mif.err}, 32'd1);
      check("t3_cnt_stay", {28'd0, mif.note_count}, 32'd1);
      tick();
      check("t3_err_off", {31'd0, mif.err}, 32'd0);
      // record_start inside RECORD clears
      pulse_start();
      check("t3_reclr_cnt", {28'd0, mif.note_count}, 32'd0);
      check("t3_reclr_data", mif.data_out, 32'd0);
      check("t3_reclr_ready", {31'd0, mif.note_ready}, 32'd1);

      // 4: eight notes auto-commit
      for (int k = 1; k <= 7; k++) note(3'(k));
      check("t4_no_we_7", {31'd0, mif.write_enable}, 32'd0);
      note(3'd7);
      check("t4_we", {31'd0, mif.write_enable}, 32'd1);
      check("t4_data", mif.data_out, 32'h7765_4321);
      check("t4_cnt", {28'd0, mif.note_count}, 32'd8);
      tick(); tick(); tick();
      check("t4_gs", {31'd0, mif.game_start}, 32'd1);
      tick();
      check("t4_cnt_sat", {28'd0, mif.note_count}, 32'd8);
      mif.game_end = 1'b1;
      tick();
      mif.game_end = 1'b0;
      check("t4_idle", {31'd0, mif.busy}, 32'd0);

      // 5: note and commit in same cycle at count 1
      pulse_start();
      note(3'd6);
      mif.note_valid = 1'b1; mif.note_in = 3'd2; mif.commit = 1'b1;
      tick();
      mif.note_valid = 1'b0; mif.note_in = 3'd0; mif.commit = 1'b0;
      check("t5_we", {31'd0, mif.write_enable}, 32'd1);
      check("t5_data", mif.data_out, 32'h0000_0026);
      check("t5_err", {31'd0, mif.err}, 32'd0);

      // 6: reset in GAP
      tick();
      check("t6_in_gap", {30'd0, mif.busy, mif.write_enable}, 32'd2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t6_rst_busy", {31'd0, mif.busy}, 32'd0);
      check("t6_rst_data", mif.data_out, 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("t6_no_gs", {31'd0, mif.game_start}, 32'd0);
         tick();
      end
      check("t6_idle_end", {31'd0, mif.busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
